// File: rtl/upcounter_ctrl_pkg.sv
// Shared definitions for the Avalon-MM event counter: register map,
// register bit positions and the sequencing FSM state encoding.
package upcounter_ctrl_pkg;

    // Word addresses on the Avalon-MM slave
    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COUNT   = 2'd1;
    localparam logic [1:0] ADDR_COMPARE = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // CTRL register bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_WRAP   = 2;
    localparam int CTRL_BITS   = 3;

    // STATUS register bits (write-1-to-clear)
    localparam int STAT_MATCH = 0;
    localparam int STAT_EXT   = 1;
    localparam int STAT_BITS  = 2;

    // Counter sequencing states
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

endpackage : upcounter_ctrl_pkg

// File: rtl/upcounter_ctrl_edge_sync.sv
// Synchroniser chain for one asynchronous input followed by a registered
// rising-edge detector producing a single-cycle pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    // fill_q[k] is set once sync_q[k] holds a real sample rather than a
    // reset zero; until the chain is full the previous level is treated as
    // high, so an input already high at reset release never reads as an edge.
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   pulse_q;

    // Shift the input through the synchroniser and detect 0->1 on its output
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
            pulse_q <= fill_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule : edge_sync

// File: rtl/upcounter_ctrl.sv
// Avalon-MM controlled event counter: synchronised count/irq inputs, a
// DISABLED/RUN/HOLD sequencer with compare match, W1C status, a level
// interrupt and a registered 16-bit copy of the count for the hex display.
module upcounter_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        counter_in,
    input  logic        ext_irq_in,
    output logic        irq,
    output logic [15:0] hex_value
);

    import upcounter_ctrl_pkg::*;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic count_pulse;
    logic ext_pulse;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_count_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (counter_in),
        .pulse_o (count_pulse)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (ext_irq_in),
        .pulse_o (ext_pulse)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CTRL_BITS-1:0] ctrl_q;
    logic [WIDTH-1:0]     count_q;
    logic [WIDTH-1:0]     compare_q;
    logic [STAT_BITS-1:0] status_q;
    logic [STAT_BITS-1:0] status_d;
    state_t               state_q;
    logic                 irq_q;
    logic [15:0]          hex_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;

    // ------------------------------------------------------------------
    // Bus decode and counting helpers
    // ------------------------------------------------------------------
    logic             wr_ctrl;
    logic             wr_count;
    logic             wr_compare;
    logic             wr_status;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] count_inc_w;
    logic             match_w;
    logic             take_pulse_w;
    logic             unused_wdata;

    assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
    assign wr_count   = avs_write && (avs_address == ADDR_COUNT);
    assign wr_compare = avs_write && (avs_address == ADDR_COMPARE);
    assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
    assign wdata_w    = avs_writedata[WIDTH-1:0];
    // Bits above the implemented fields are accepted and discarded
    assign unused_wdata = ^avs_writedata;

    assign count_inc_w = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    // compare_q is the pre-write value, so a COMPARE write in the same cycle
    // as a pulse does not affect that pulse
    assign match_w     = (count_inc_w == compare_q);
    // A COUNT write in the same cycle as a pulse wins; the pulse is dropped
    assign take_pulse_w = count_pulse && (state_q == ST_RUN) && !wr_count;

    // Zero-extended views of the count/compare for readback and display
    logic [31:0] count_ext;
    logic [31:0] compare_ext;
    logic [15:0] hex_src;

    generate
        if (WIDTH < 32) begin : g_ext_narrow
            assign count_ext   = {{(32-WIDTH){1'b0}}, count_q};
            assign compare_ext = {{(32-WIDTH){1'b0}}, compare_q};
        end else begin : g_ext_full
            assign count_ext   = count_q;
            assign compare_ext = compare_q;
        end

        if (WIDTH < 16) begin : g_hex_narrow
            assign hex_src = {{(16-WIDTH){1'b0}}, count_q};
        end else begin : g_hex_full
            assign hex_src = count_q[15:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer: CTRL/COUNT/COMPARE registers and the counting FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '1;
            state_q   <= ST_DISABLED;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= avs_writedata[CTRL_BITS-1:0];
            end
            if (wr_compare) begin
                compare_q <= wdata_w;
            end

            if (wr_count) begin
                count_q <= wdata_w;
            end else if (take_pulse_w) begin
                if (match_w && ctrl_q[CTRL_WRAP]) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_inc_w;
                end
            end

            case (state_q)
                ST_DISABLED: begin
                    if (wr_ctrl && avs_writedata[CTRL_EN]) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wr_ctrl && !avs_writedata[CTRL_EN]) begin
                        state_q <= ST_DISABLED;
                    end else if (take_pulse_w && match_w && !ctrl_q[CTRL_WRAP]) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Re-enabling via CTRL alone keeps the frozen count;
                    // reloading COUNT or COMPARE restarts counting.
                    if (wr_ctrl && !avs_writedata[CTRL_EN]) begin
                        state_q <= ST_DISABLED;
                    end else if ((wr_count || wr_compare) && ctrl_q[CTRL_EN]) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_DISABLED;
                end
            endcase
        end
    end

    // Status next value: new events take priority over a same-cycle W1C
    always_comb begin
        status_d = status_q;
        if (wr_status) begin
            status_d = status_d & ~avs_writedata[STAT_BITS-1:0];
        end
        if (take_pulse_w && match_w) begin
            status_d[STAT_MATCH] = 1'b1;
        end
        if (ext_pulse) begin
            status_d[STAT_EXT] = 1'b1;
        end
    end

    // Status register
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // Read mux; unimplemented bits read as zero
    always_comb begin
        rdata_d = 32'd0;
        case (avs_address)
            ADDR_CTRL:    rdata_d[CTRL_BITS-1:0] = ctrl_q;
            ADDR_COUNT:   rdata_d = count_ext;
            ADDR_COMPARE: rdata_d = compare_ext;
            ADDR_STATUS:  rdata_d[STAT_BITS-1:0] = status_q;
            default:      rdata_d = 32'd0;
        endcase
    end

    // Registered outputs: read data held between reads, irq level, display
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
            hex_q   <= '0;
        end else begin
            if (avs_read) begin
                rdata_q <= rdata_d;
            end
            irq_q <= ctrl_q[CTRL_IRQ_EN] & (status_q[STAT_MATCH] | status_q[STAT_EXT]);
            hex_q <= hex_src;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign hex_value    = hex_q;

endmodule : upcounter_ctrl

// File: tb/tb_upcounter_ctrl.sv
// Directed bench for upcounter_ctrl: a vector table for the register-level
// sequences plus hand-written multi-cycle corner cases. A WIDTH=16 instance
// shares the bus and is checked in the overflow/compare=0 case.
module tb_upcounter_ctrl;

    import upcounter_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] rdata32;
    logic [31:0] rdata16;
    logic        counter_in;
    logic        ext_irq_in;
    logic        irq32;
    logic        irq16;
    logic [15:0] hex32;
    logic [15:0] hex16;

    always #5 clk = ~clk;

    upcounter_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (rdata32),
        .counter_in    (counter_in),
        .ext_irq_in    (ext_irq_in),
        .irq           (irq32),
        .hex_value     (hex32)
    );

    upcounter_ctrl #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (rdata16),
        .counter_in    (counter_in),
        .ext_irq_in    (ext_irq_in),
        .irq           (irq16),
        .hex_value     (hex16)
    );

    int tests = 0;
    int fails = 0;

    localparam int K_WR    = 0;
    localparam int K_RD    = 1;
    localparam int K_PULSE = 2;
    localparam int K_IRQ   = 3;
    localparam int K_HEX   = 4;
    localparam int K_IDLE  = 5;

    typedef struct {
        int          kind;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int kind, input logic [1:0] addr,
                       input logic [31:0] data, input logic [31:0] exp);
        vec_t v;
        v.kind = kind;
        v.addr = addr;
        v.data = data;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] d32,
                            output logic [31:0] d16);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d32         = rdata32;
        d16         = rdata16;
    endtask

    task automatic count_pulses(input int n);
        for (int p = 0; p < n; p++) begin
            counter_in = 1'b1;
            repeat (2) tick();
            counter_in = 1'b0;
            repeat (4) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d32;
        logic [31:0] d16;
        int seq_exp[7];

        reset         = 1'b1;
        avs_address   = 2'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        avs_read      = 1'b0;
        counter_in    = 1'b0;
        ext_irq_in    = 1'b0;

        // ---------------- vector table ----------------
        // Reset state
        add(K_RD,  ADDR_CTRL,    0, 32'h0);
        add(K_RD,  ADDR_COUNT,   0, 32'h0);
        add(K_RD,  ADDR_COMPARE, 0, 32'hFFFF_FFFF);
        add(K_RD,  ADDR_STATUS,  0, 32'h0);
        add(K_IRQ, 0, 0, 0);
        add(K_HEX, 0, 0, 0);
        // Stop at compare without wrap, irq masked until IRQ_EN
        add(K_WR,    ADDR_COMPARE, 5, 0);
        add(K_WR,    ADDR_CTRL,    1, 0);
        add(K_PULSE, 0, 7, 0);
        add(K_RD,    ADDR_COUNT,  0, 5);
        add(K_RD,    ADDR_STATUS, 0, 1);
        add(K_IRQ,   0, 0, 0);
        add(K_HEX,   0, 0, 5);
        add(K_WR,    ADDR_CTRL, 3, 0);
        add(K_IRQ,   0, 0, 0);
        add(K_IDLE,  0, 1, 0);
        add(K_IRQ,   0, 0, 1);
        add(K_PULSE, 0, 2, 0);
        add(K_RD,    ADDR_COUNT, 0, 5);
        // Wrap mode: HOLD -> RUN via COUNT write, sequence 1,2,0,...
        add(K_WR, ADDR_STATUS,  3, 0);
        add(K_WR, ADDR_CTRL,    7, 0);
        add(K_WR, ADDR_COUNT,   0, 0);
        add(K_WR, ADDR_COMPARE, 3, 0);
        seq_exp = '{1, 2, 0, 1, 2, 0, 1};
        for (int s = 0; s < 7; s++) begin
            add(K_PULSE, 0, 1, 0);
            add(K_RD, ADDR_COUNT, 0, seq_exp[s]);
        end
        add(K_RD,   ADDR_STATUS, 0, 1);
        add(K_IRQ,  0, 0, 1);
        add(K_WR,   ADDR_STATUS, 1, 0);
        add(K_IRQ,  0, 0, 1);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ,  0, 0, 0);
        add(K_RD,   ADDR_STATUS, 0, 0);

        repeat (3) tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_WR:    bus_write(vecs[i].addr, vecs[i].data);
                K_RD: begin
                    bus_read(vecs[i].addr, d32, d16);
                    check($sformatf("vec%0d_read_a%0d", i, vecs[i].addr), d32, vecs[i].exp);
                end
                K_PULSE: count_pulses(int'(vecs[i].data));
                K_IRQ:   check($sformatf("vec%0d_irq", i), {31'd0, irq32}, vecs[i].exp);
                K_HEX:   check($sformatf("vec%0d_hex", i), {16'd0, hex32}, vecs[i].exp);
                K_IDLE:  repeat (int'(vecs[i].data)) tick();
                default: ;
            endcase
        end

        // ---------------- pulse latency: edge at n -> count at n+3 ----------
        bus_write(ADDR_COMPARE, 32'd100);
        bus_write(ADDR_COUNT, 32'd20);
        avs_address = ADDR_COUNT;
        avs_read    = 1'b1;
        counter_in  = 1'b1;
        tick();                 // edge n samples the input
        tick();                 // n+1
        tick();                 // n+2
        tick();                 // n+3: read captures pre-update count
        check("lat_read_n3", rdata32, 32'd20);
        check("lat_hex_n3", {16'd0, hex32}, 32'd20);
        tick();                 // n+4
        check("lat_read_n4", rdata32, 32'd21);
        check("lat_hex_n4", {16'd0, hex32}, 32'd21);
        avs_read   = 1'b0;
        counter_in = 1'b0;
        repeat (4) tick();

        // ---------------- COUNT write collides with a pulse ----------------
        counter_in = 1'b1;
        repeat (3) tick();      // pulse is high going into edge n+3
        avs_address   = ADDR_COUNT;
        avs_writedata = 32'd10;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        counter_in    = 1'b0;
        repeat (4) tick();
        bus_read(ADDR_COUNT, d32, d16);
        check("write_beats_pulse", d32, 32'd10);

        // ---------------- EXT while DISABLED ----------------
        bus_write(ADDR_CTRL, 32'h2);
        bus_write(ADDR_STATUS, 32'h3);
        counter_in = 1'b1;
        ext_irq_in = 1'b1;
        repeat (2) tick();
        counter_in = 1'b0;
        ext_irq_in = 1'b0;
        repeat (4) tick();
        bus_read(ADDR_STATUS, d32, d16);
        check("ext_disabled_status", d32, 32'h2);
        check("ext_disabled_irq", {31'd0, irq32}, 32'd1);
        bus_read(ADDR_COUNT, d32, d16);
        check("disabled_count_held", d32, 32'd10);

        // W1C of EXT in the same cycle as a new EXT pulse: set wins
        ext_irq_in = 1'b1;
        repeat (3) tick();
        avs_address   = ADDR_STATUS;
        avs_writedata = 32'h2;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        ext_irq_in    = 1'b0;
        repeat (4) tick();
        bus_read(ADDR_STATUS, d32, d16);
        check("w1c_vs_set", d32, 32'h2);
        bus_write(ADDR_STATUS, 32'h2);
        bus_read(ADDR_STATUS, d32, d16);
        check("w1c_clear", d32, 32'h0);
        check("irq_after_clear", {31'd0, irq32}, 32'd0);

        // ---------------- compare=0 matches on overflow (WIDTH=16) ---------
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_STATUS, 32'h3);
        bus_write(ADDR_COUNT, 32'h0000_FFFF);
        bus_write(ADDR_COMPARE, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        count_pulses(1);
        bus_read(ADDR_COUNT, d32, d16);
        check("w16_overflow_count", d16, 32'h0);
        check("w32_no_overflow_count", d32, 32'h0001_0000);
        bus_read(ADDR_STATUS, d32, d16);
        check("w16_overflow_match", d16, 32'h1);
        check("w32_no_match", d32, 32'h0);
        check("w16_hex", {16'd0, hex16}, 32'h0);
        check("w32_hex", {16'd0, hex32}, 32'h0);
        count_pulses(1);
        bus_read(ADDR_COUNT, d32, d16);
        check("w16_hold_after_match", d16, 32'h0);
        check("w32_still_running", d32, 32'h0001_0001);

        // ---------------- reset mid-operation, input held high -------------
        counter_in = 1'b1;
        reset      = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus_write(ADDR_CTRL, 32'h1);
        repeat (6) tick();
        bus_read(ADDR_COUNT, d32, d16);
        check("rst_high_input_no_count", d32, 32'h0);
        bus_read(ADDR_COMPARE, d32, d16);
        check("rst_compare", d32, 32'hFFFF_FFFF);
        bus_read(ADDR_STATUS, d32, d16);
        check("rst_status", d32, 32'h0);
        check("rst_irq", {31'd0, irq32}, 32'd0);
        check("rst_hex", {16'd0, hex32}, 32'h0);
        counter_in = 1'b0;
        repeat (4) tick();
        bus_read(ADDR_COUNT, d32, d16);
        check("rst_fall_no_count", d32, 32'h0);
        count_pulses(1);
        bus_read(ADDR_COUNT, d32, d16);
        check("rst_then_count", d32, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_upcounter_ctrl
